// File: rtl/am2940_dma_ctrl.sv
// rtl/am2940_dma_ctrl.sv - sequencer that programs and steps an am2940 DMA address generator
module am2940_dma_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rstneg,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cr_in,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             done_in,
  input  logic             mem_ack,
  output logic [2:0]       instr,
  output logic [WIDTH-1:0] data_out,
  output logic             acineg,
  output logic             wcineg,
  output logic             mem_req,
  output logic             busy,
  output logic             complete,
  output logic             err,
  output logic [WIDTH-1:0] xfer_count
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] I_LOAD_CR   = 3'b000;
  localparam logic [2:0] I_READ_CR   = 3'b001;
  localparam logic [2:0] I_LOAD_ADDR = 3'b101;
  localparam logic [2:0] I_LOAD_WC   = 3'b110;
  localparam logic [2:0] I_ENABLE    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_CR,
    S_LD_ADDR,
    S_LD_WC,
    S_REQ,
    S_STEP,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cr_q, cr_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] xfer_q, xfer_d;
  logic [2:0]       instr_q, instr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             acineg_q, acineg_d;
  logic             wcineg_q, wcineg_d;
  logic             mem_req_q, mem_req_d;
  logic             busy_q, busy_d;
  logic             complete_q, complete_d;

  // Next-state logic: program sequence, handshake wait with timeout, abort override
  always_comb begin
    state_d = state_q;
    cr_d    = cr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    last_d  = last_q;
    err_d   = err_q;
    xfer_d  = xfer_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Mode 3 never raises done, so a run in that mode could never end
          if (cr_in[1:0] == 2'b11) begin
            err_d = 1'b1;
          end else begin
            cr_d    = cr_in;
            addr_d  = addr_in;
            cnt_d   = cnt_in;
            err_d   = 1'b0;
            xfer_d  = '0;
            state_d = S_LD_CR;
          end
        end
      end
      S_LD_CR:   state_d = S_LD_ADDR;
      S_LD_ADDR: state_d = S_LD_WC;
      S_LD_WC:   state_d = S_REQ;
      S_REQ: begin
        if (mem_ack) begin
          // done_in is sampled before the counters move, so it flags this transfer as the last
          last_d  = done_in;
          xfer_d  = xfer_q + WIDTH'(1);
          state_d = S_STEP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_STEP:   state_d = last_q ? S_FINISH : S_REQ;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      xfer_d  = xfer_q;
      last_d  = last_q;
      tmo_d   = '0;
    end
  end

  // Output decode from the next state so the registered outputs line up with the state
  always_comb begin
    instr_d    = I_READ_CR;
    data_d     = '0;
    acineg_d   = 1'b1;
    wcineg_d   = 1'b1;
    mem_req_d  = 1'b0;
    busy_d     = (state_d != S_IDLE);
    complete_d = 1'b0;
    case (state_d)
      S_LD_CR: begin
        instr_d = I_LOAD_CR;
        data_d  = cr_d;
      end
      S_LD_ADDR: begin
        instr_d = I_LOAD_ADDR;
        data_d  = addr_d;
      end
      S_LD_WC: begin
        instr_d = I_LOAD_WC;
        data_d  = cnt_d;
      end
      S_REQ: begin
        instr_d   = I_ENABLE;
        mem_req_d = 1'b1;
      end
      S_STEP: begin
        instr_d  = I_ENABLE;
        acineg_d = 1'b0;
        wcineg_d = 1'b0;
      end
      S_FINISH: complete_d = 1'b1;
      default: ;
    endcase
  end

  // State, latched program values and registered outputs
  always_ff @(posedge clk or negedge rstneg) begin
    if (!rstneg) begin
      state_q    <= S_IDLE;
      cr_q       <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      xfer_q     <= '0;
      instr_q    <= I_READ_CR;
      data_q     <= '0;
      acineg_q   <= 1'b1;
      wcineg_q   <= 1'b1;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cr_q       <= cr_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      last_q     <= last_d;
      err_q      <= err_d;
      xfer_q     <= xfer_d;
      instr_q    <= instr_d;
      data_q     <= data_d;
      acineg_q   <= acineg_d;
      wcineg_q   <= wcineg_d;
      mem_req_q  <= mem_req_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
    end
  end

  assign instr      = instr_q;
  assign data_out   = data_q;
  assign acineg     = acineg_q;
  assign wcineg     = wcineg_q;
  assign mem_req    = mem_req_q;
  assign busy       = busy_q;
  assign complete   = complete_q;
  assign err        = err_q;
  assign xfer_count = xfer_q;

endmodule
